// File: rtl/videogen_timing_pkg.sv
// Shared types and constants for the raster timing generator and its users.
// Counter widths, the timing-config bundle and a reference 640x480@60 setting.
package videogen_timing_pkg;

    localparam int HCNT_W = 12;
    localparam int VCNT_W = 11;

    typedef struct packed {
        logic [HCNT_W-1:0] h_total;
        logic [HCNT_W-1:0] h_active;
        logic [7:0]        h_synclen;
        logic [8:0]        h_backporch;
        logic [VCNT_W-1:0] v_total;
        logic [VCNT_W-1:0] v_active;
        logic [3:0]        v_synclen;
        logic [8:0]        v_backporch;
    } timing_cfg_t;

    localparam timing_cfg_t VGA_640X480_CFG = '{
        h_total:     12'd800,
        h_active:    12'd640,
        h_synclen:   8'd96,
        h_backporch: 9'd48,
        v_total:     11'd525,
        v_active:    11'd480,
        v_synclen:   4'd2,
        v_backporch: 9'd33
    };

    // A raster needs at least two positions per axis to form a line/frame.
    function automatic logic cfg_degenerate(input timing_cfg_t cfg);
        return (cfg.h_total < HCNT_W'(2)) || (cfg.v_total < VCNT_W'(2));
    endfunction

endpackage

// File: rtl/videogen_delay_line.sv
// Fixed-depth register pipeline with a per-bit reset value.
// Used to align sync/DE with a downstream pipeline of known latency.
module videogen_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge pclk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/videogen_timing.sv
// Programmable raster timing generator: scan coordinates for the pattern generator
// plus active-low HSYNC/VSYNC and DE delayed to match the pattern pipeline.
module videogen_timing
    import videogen_timing_pkg::*;
#(
    parameter int PAT_LATENCY = 1
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [11:0]       H_TOTAL,
    input  logic [11:0]       H_ACTIVE,
    input  logic [7:0]        H_SYNCLEN,
    input  logic [8:0]        H_BACKPORCH,
    input  logic [10:0]       V_TOTAL,
    input  logic [10:0]       V_ACTIVE,
    input  logic [3:0]        V_SYNCLEN,
    input  logic [8:0]        V_BACKPORCH,
    output logic [HCNT_W-1:0] xpos,
    output logic [VCNT_W-1:0] ypos,
    output logic              HSYNC_out,
    output logic              VSYNC_out,
    output logic              DE_out,
    output logic              frame_start
);

    timing_cfg_t       cfg_in;
    timing_cfg_t       shadow;
    logic [HCNT_W-1:0] h_cnt;
    logic [VCNT_W-1:0] v_cnt;
    logic              degenerate;
    logic              h_last;
    logic              v_last;
    logic              frame_wrap;

    assign cfg_in = '{
        h_total:     H_TOTAL,
        h_active:    H_ACTIVE,
        h_synclen:   H_SYNCLEN,
        h_backporch: H_BACKPORCH,
        v_total:     V_TOTAL,
        v_active:    V_ACTIVE,
        v_synclen:   V_SYNCLEN,
        v_backporch: V_BACKPORCH
    };

    assign degenerate = cfg_degenerate(shadow);
    assign h_last     = (h_cnt == shadow.h_total - HCNT_W'(1));
    assign v_last     = (v_cnt == shadow.v_total - VCNT_W'(1));
    // A degenerate raster has no real wrap, so keep sampling the inputs;
    // otherwise it could never leave that state (e.g. right after reset).
    assign frame_wrap = degenerate || (h_last && v_last);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (!enable || frame_wrap) begin
            shadow <= cfg_in;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable || degenerate) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VCNT_W'(1);
        end else begin
            h_cnt <= h_cnt + HCNT_W'(1);
        end
    end

    // Window edges are kept one bit wider than the counters so that large
    // back porch + active sums never wrap into the start of the line/frame.
    logic [HCNT_W:0]   hstart;
    logic [HCNT_W:0]   hend;
    logic [VCNT_W:0]   vstart;
    logic [VCNT_W:0]   vend;
    logic              h_ge;
    logic              v_ge;
    logic              h_act;
    logic              v_act;
    logic              hs_c;
    logic              vs_c;
    logic [HCNT_W-1:0] xpos_c;
    logic [VCNT_W-1:0] ypos_c;

    assign hstart = (HCNT_W+1)'(shadow.h_synclen) + (HCNT_W+1)'(shadow.h_backporch);
    assign hend   = hstart + (HCNT_W+1)'(shadow.h_active);
    assign vstart = (VCNT_W+1)'(shadow.v_synclen) + (VCNT_W+1)'(shadow.v_backporch);
    assign vend   = vstart + (VCNT_W+1)'(shadow.v_active);

    assign h_ge   = ({1'b0, h_cnt} >= hstart);
    assign v_ge   = ({1'b0, v_cnt} >= vstart);
    assign h_act  = h_ge && ({1'b0, h_cnt} < hend);
    assign v_act  = v_ge && ({1'b0, v_cnt} < vend);
    assign hs_c   = (h_cnt < HCNT_W'(shadow.h_synclen));
    assign vs_c   = (v_cnt < VCNT_W'(shadow.v_synclen));
    assign xpos_c = h_ge ? (h_cnt - hstart[HCNT_W-1:0]) : '0;
    assign ypos_c = v_ge ? (v_cnt - vstart[VCNT_W-1:0]) : '0;

    logic hs1;
    logic vs1;
    logic de1;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            de1         <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            de1         <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            frame_start <= 1'b0;
        end else begin
            hs1         <= hs_c;
            vs1         <= vs_c;
            de1         <= h_act && v_act && !degenerate;
            xpos        <= xpos_c;
            ypos        <= ypos_c;
            frame_start <= (h_cnt == '0) && (v_cnt == '0) && !degenerate;
        end
    end

    // Pipe carries the output polarity so its reset value is the idle level.
    logic [2:0] sync_d;
    logic [2:0] sync_q;

    assign sync_d = {~hs1, ~vs1, de1};

    videogen_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PAT_LATENCY),
        .RESET_VAL (3'b110)
    ) u_sync_delay (
        .pclk    (pclk),
        .reset_n (reset_n),
        .d       (sync_d),
        .q       (sync_q)
    );

    assign HSYNC_out = sync_q[2];
    assign VSYNC_out = sync_q[1];
    assign DE_out    = sync_q[0];

endmodule

// File: tb/tb_videogen_timing.sv
// Directed bench for videogen_timing: 640x480 line-level timing, a small raster
// for full-frame checks, shadow-register behaviour, reset, enable and degenerate config.
module tb_videogen_timing;
    import videogen_timing_pkg::*;

    localparam int LAT = 1;

    logic        pclk;
    logic        reset_n;
    logic        enable;
    logic [11:0] H_TOTAL;
    logic [11:0] H_ACTIVE;
    logic [7:0]  H_SYNCLEN;
    logic [8:0]  H_BACKPORCH;
    logic [10:0] V_TOTAL;
    logic [10:0] V_ACTIVE;
    logic [3:0]  V_SYNCLEN;
    logic [8:0]  V_BACKPORCH;
    logic [11:0] xpos;
    logic [10:0] ypos;
    logic        HSYNC_out;
    logic        VSYNC_out;
    logic        DE_out;
    logic        frame_start;

    int tests_run    = 0;
    int tests_failed = 0;

    // capture statistics
    int          de_cnt [2];
    logic [11:0] last_x [2];
    logic [10:0] last_y [2];
    int          fs_cnt, fs_first_k, first_de_k, hs_line1, vs_cnt, raster_err, x_cnt;

    videogen_timing #(.PAT_LATENCY(LAT)) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .enable      (enable),
        .H_TOTAL     (H_TOTAL),
        .H_ACTIVE    (H_ACTIVE),
        .H_SYNCLEN   (H_SYNCLEN),
        .H_BACKPORCH (H_BACKPORCH),
        .V_TOTAL     (V_TOTAL),
        .V_ACTIVE    (V_ACTIVE),
        .V_SYNCLEN   (V_SYNCLEN),
        .V_BACKPORCH (V_BACKPORCH),
        .xpos        (xpos),
        .ypos        (ypos),
        .HSYNC_out   (HSYNC_out),
        .VSYNC_out   (VSYNC_out),
        .DE_out      (DE_out),
        .frame_start (frame_start)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input timing_cfg_t c);
        H_TOTAL     = c.h_total;
        H_ACTIVE    = c.h_active;
        H_SYNCLEN   = c.h_synclen;
        H_BACKPORCH = c.h_backporch;
        V_TOTAL     = c.v_total;
        V_ACTIVE    = c.v_active;
        V_SYNCLEN   = c.v_synclen;
        V_BACKPORCH = c.v_backporch;
    endtask

    // Sample n_cyc negedges starting with the first enabled cycle (k=0).
    // xpos/ypos are re-aligned to DE_out using a LAT-deep history.
    task automatic run_capture(input int htot, input int ftot, input int n_cyc,
                               input int change_k, input logic [11:0] new_hact);
        logic [11:0] xh [8];
        logic [10:0] yh [8];
        logic [11:0] ax, px;
        logic [10:0] ay, py;
        int f, pf;
        for (int i = 0; i < 8; i++) begin
            xh[i] = '0;
            yh[i] = '0;
        end
        de_cnt[0] = 0; de_cnt[1] = 0;
        last_x[0] = '0; last_x[1] = '0;
        last_y[0] = '0; last_y[1] = '0;
        fs_cnt = 0; fs_first_k = -1; first_de_k = -1;
        hs_line1 = 0; vs_cnt = 0; raster_err = 0; x_cnt = 0;
        pf = -1; px = '0; py = '0;
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge pclk);
            for (int i = 7; i > 0; i--) begin
                xh[i] = xh[i-1];
                yh[i] = yh[i-1];
            end
            xh[0] = xpos;
            yh[0] = ypos;
            ax = xh[LAT];
            ay = yh[LAT];
            if ($isunknown({xpos, ypos, HSYNC_out, VSYNC_out, DE_out, frame_start})) x_cnt++;
            if (frame_start) begin
                if (fs_cnt == 0) fs_first_k = k;
                fs_cnt++;
            end
            if (!VSYNC_out) vs_cnt++;
            if (!HSYNC_out && k >= htot + LAT && k < 2*htot + LAT) hs_line1++;
            if (DE_out) begin
                f = (k < LAT) ? 0 : (k - LAT) / ftot;
                if (f > 1) f = 1;
                if (first_de_k < 0) first_de_k = k;
                if (f != pf) begin
                    if (ax != 0 || ay != 0) raster_err++;
                end else if (!((ax == px + 1 && ay == py) || (ax == 0 && ay == py + 1))) begin
                    raster_err++;
                end
                pf = f; px = ax; py = ay;
                de_cnt[f]++;
                last_x[f] = ax;
                last_y[f] = ay;
            end
            if (k == change_k) H_ACTIVE = new_hact;
        end
    endtask

    timing_cfg_t small_cfg;
    int found;
    int bad;

    initial begin
        small_cfg = '{h_total: 12'd20, h_active: 12'd10, h_synclen: 8'd3, h_backporch: 9'd4,
                      v_total: 11'd12, v_active: 11'd6,  v_synclen: 4'd2, v_backporch: 9'd2};
        reset_n = 1'b0;
        enable  = 1'b0;
        set_cfg(VGA_640X480_CFG);
        #12;
        chk("rst_xpos",  xpos, 0);
        chk("rst_ypos",  ypos, 0);
        chk("rst_hsync", HSYNC_out, 1);
        chk("rst_vsync", VSYNC_out, 1);
        chk("rst_de",    DE_out, 0);
        chk("rst_fs",    frame_start, 0);
        @(negedge pclk);
        reset_n = 1'b1;
        repeat (3) @(negedge pclk);

        // 640x480: first 36 lines
        enable = 1'b1;
        run_capture(800, 420000, 36*800 + 1, -1, 12'd0);
        chk("vga_fs_first_k",   fs_first_k, 0);
        chk("vga_fs_cnt",       fs_cnt, 1);
        chk("vga_hs_low_line",  hs_line1, 96);
        chk("vga_vs_low",       vs_cnt, 1600);
        chk("vga_first_de_k",   first_de_k, 35*800 + 144 + LAT);
        chk("vga_de_line",      de_cnt[0], 640);
        chk("vga_raster",       raster_err, 0);
        chk("vga_last_x",       last_x[0], 639);
        chk("vga_last_y",       last_y[0], 0);
        chk("vga_no_x",         x_cnt, 0);

        // small raster, two frames, H_ACTIVE 10->5 mid-frame 0
        @(negedge pclk);
        enable = 1'b0;
        set_cfg(small_cfg);
        repeat (2) @(negedge pclk);
        enable = 1'b1;
        run_capture(20, 240, 480, 50, 12'd5);
        chk("sm_fs_first_k",  fs_first_k, 0);
        chk("sm_fs_cnt",      fs_cnt, 2);
        chk("sm_hs_low_line", hs_line1, 3);
        chk("sm_vs_low",      vs_cnt, 80);
        chk("sm_first_de_k",  first_de_k, 4*20 + 7 + LAT);
        chk("sm_de_frame0",   de_cnt[0], 60);
        chk("sm_de_frame1",   de_cnt[1], 30);
        chk("sm_raster",      raster_err, 0);
        chk("sm_last_x0",     last_x[0], 9);
        chk("sm_last_y0",     last_y[0], 5);
        chk("sm_last_x1",     last_x[1], 4);
        chk("sm_last_y1",     last_y[1], 5);

        // asynchronous reset in the middle of an active line
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge pclk);
            if (DE_out) found = 1;
        end
        chk("pre_reset_de_seen", found, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_de",    DE_out, 0);
        chk("async_rst_hsync", HSYNC_out, 1);
        chk("async_rst_vsync", VSYNC_out, 1);
        chk("async_rst_xpos",  xpos, 0);
        repeat (3) @(negedge pclk);
        reset_n = 1'b1;
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            @(negedge pclk);
            if (frame_start) found = 1;
        end
        chk("post_rst_fs_seen", found, 1);
        chk("post_rst_xpos",    xpos, 0);
        chk("post_rst_ypos",    ypos, 0);

        // enable 1->0->1 during the active area
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge pclk);
            if (DE_out) found = 1;
        end
        chk("pre_dis_de_seen", found, 1);
        enable = 1'b0;
        repeat (LAT) @(negedge pclk);
        chk("dis_de_still_piped", DE_out, 1);
        @(negedge pclk);
        chk("dis_de",    DE_out, 0);
        chk("dis_hsync", HSYNC_out, 1);
        chk("dis_vsync", VSYNC_out, 1);
        chk("dis_fs",    frame_start, 0);
        repeat (3) @(negedge pclk);
        enable = 1'b1;
        @(negedge pclk);
        chk("reen_fs",   frame_start, 1);
        chk("reen_xpos", xpos, 0);
        chk("reen_ypos", ypos, 0);
        @(negedge pclk);
        chk("reen_fs_pulse", frame_start, 0);

        // degenerate H_TOTAL=1
        enable = 1'b0;
        H_TOTAL = 12'd1;
        repeat (2) @(negedge pclk);
        enable = 1'b1;
        found = 0;
        bad   = 0;
        x_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (DE_out) found++;
            if (xpos != 0 || ypos != 0) bad++;
            if ($isunknown({xpos, ypos, HSYNC_out, VSYNC_out, DE_out, frame_start})) x_cnt++;
        end
        chk("degen_de_cnt", found, 0);
        chk("degen_pos",    bad, 0);
        chk("degen_no_x",   x_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
